// File: rtl/nv_nvdla_mcif_rd_ig_pkg.sv
// Shared constants and helpers for the MCIF read-ingress elastic pipes.
// The defaults here are used by every per-requester pipe instance.
package nv_nvdla_mcif_rd_ig_pkg;

  localparam int MCIF_RD_REQ_PD_W = 75;
  localparam int MCIF_RD_IG_DEPTH = 2;
  localparam int MCIF_RD_IG_HWM   = MCIF_RD_IG_DEPTH - 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_ctl.sv
// Pointer, occupancy and handshake control for the read-ingress elastic pipe.
// Owns everything except payload storage.
module nv_nvdla_mcif_rd_ig_elastic_ctl
  import nv_nvdla_mcif_rd_ig_pkg::*;
#(
  parameter int  DEPTH   = MCIF_RD_IG_DEPTH,
  parameter int  REG_RDY = 1,
  parameter int  HWM     = DEPTH - 1,
  localparam int CW      = clog2(DEPTH + 1),
  localparam int PW      = clog2(DEPTH)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          in_ready,
  output logic          out_valid,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] occupancy,
  output logic          hwm
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HWM_C   = CW'(HWM);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic          hwm_q, hwm_d;
  logic          in_ready_q, in_ready_d;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign in_ready = (REG_RDY != 0) ? in_ready_q : ((count_q != DEPTH_C) | out_ready);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid_q & out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    out_valid_d = (count_d != '0);
    hwm_d       = (count_d >= HWM_C);
    in_ready_d  = (count_d < DEPTH_C) | flush;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      hwm_q       <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      hwm_q       <= hwm_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign occupancy = count_q;
  assign hwm       = hwm_q;

endmodule

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_pipe.sv
// Elastic valid/ready pipe between a bpt requester and the read-ingress arbiter.
// Holds the payload array and read mux; control lives in the _ctl sub-module.
module nv_nvdla_mcif_rd_ig_elastic_pipe
  import nv_nvdla_mcif_rd_ig_pkg::*;
#(
  parameter int  DW      = MCIF_RD_REQ_PD_W,
  parameter int  DEPTH   = MCIF_RD_IG_DEPTH,
  parameter int  REG_RDY = 1,
  parameter int  HWM     = DEPTH - 1,
  localparam int CW      = clog2(DEPTH + 1)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pd,
  input  logic          flush,
  output logic [CW-1:0] occupancy,
  output logic          hwm
);

  localparam int PW = clog2(DEPTH);

  logic          push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem_q [DEPTH];

  nv_nvdla_mcif_rd_ig_elastic_ctl #(
    .DEPTH   (DEPTH),
    .REG_RDY (REG_RDY),
    .HWM     (HWM)
  ) u_ctl (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_valid        (in_valid),
    .out_ready       (out_ready),
    .flush           (flush),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .push            (push),
    .pop             (pop),
    .wr_ptr          (wr_ptr),
    .rd_ptr          (rd_ptr),
    .occupancy       (occupancy),
    .hwm             (hwm)
  );

  // Storage is deliberately unreset; out_pd is only meaningful with out_valid.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem_q[wr_ptr] <= in_pd;
  end

  assign out_pd = mem_q[rd_ptr];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(push && !pop && (occupancy == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(pop && (occupancy == '0)));
  a_out_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_pd)));
`endif

endmodule
